// File: rtl/button_debounce_pulse_pkg.sv
// rtl/button_debounce_pulse_pkg.sv - shared counter-path state encodings and width helper
package button_debounce_pulse_pkg;

  typedef enum logic [1:0] {
    IDLE         = 2'd0,
    PRESS_WAIT   = 2'd1,
    HELD         = 2'd2,
    RELEASE_WAIT = 2'd3
  } state_t;

  // Smallest width that can represent the value n itself.
  function automatic int cnt_width(input int n);
    return (n < 2) ? 1 : $clog2(n + 1);
  endfunction

endpackage

// File: rtl/sync_2ff.sv
// rtl/sync_2ff.sv - two-flop synchronizer for an asynchronous single-bit level
module sync_2ff (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/button_debounce_pulse.sv
// rtl/button_debounce_pulse.sv - debounced button level plus one-cycle count-enable strobe
module button_debounce_pulse
  import button_debounce_pulse_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 16,
  parameter int REPEAT_EN       = 0,
  parameter int REPEAT_DELAY    = 64,
  parameter int REPEAT_PERIOD   = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_in,
  output logic pulse,
  output logic level
);

  localparam int CW   = cnt_width(DEBOUNCE_CYCLES);
  localparam int RMAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int RCW  = cnt_width(RMAX);

  localparam logic [CW-1:0]  CNT_LAST    = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [RCW-1:0] DELAY_LAST  = RCW'(REPEAT_DELAY - 1);
  localparam logic [RCW-1:0] PERIOD_LAST = RCW'(REPEAT_PERIOD - 1);

  logic           btn_s;
  state_t         state, state_n;
  logic [CW-1:0]  cnt, cnt_n;
  logic [RCW-1:0] rcnt, rcnt_n;
  logic           rphase, rphase_n;
  logic           pulse_n, level_n;

  sync_2ff u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (btn_in),
    .q     (btn_s)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      cnt    <= '0;
      rcnt   <= '0;
      rphase <= 1'b0;
      pulse  <= 1'b0;
      level  <= 1'b0;
    end else begin
      state  <= state_n;
      cnt    <= cnt_n;
      rcnt   <= rcnt_n;
      rphase <= rphase_n;
      pulse  <= pulse_n;
      level  <= level_n;
    end
  end

  // rphase selects the first-repeat delay (0) or the steady repeat period (1).
  always_comb begin
    state_n  = state;
    cnt_n    = cnt;
    rcnt_n   = rcnt;
    rphase_n = rphase;
    pulse_n  = 1'b0;
    case (state)
      IDLE: begin
        if (btn_s) begin
          state_n = PRESS_WAIT;
          cnt_n   = '0;
        end
      end
      PRESS_WAIT: begin
        if (!btn_s) begin
          state_n = IDLE;
        end else if (cnt == CNT_LAST) begin
          state_n  = HELD;
          pulse_n  = 1'b1;
          rcnt_n   = '0;
          rphase_n = 1'b0;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      HELD: begin
        if (!btn_s) begin
          state_n = RELEASE_WAIT;
          cnt_n   = '0;
        end else if (REPEAT_EN != 0) begin
          if (rcnt == (rphase ? PERIOD_LAST : DELAY_LAST)) begin
            pulse_n  = 1'b1;
            rcnt_n   = '0;
            rphase_n = 1'b1;
          end else begin
            rcnt_n = rcnt + 1'b1;
          end
        end
      end
      RELEASE_WAIT: begin
        // rcnt is left untouched here so a release bounce resumes the repeat timing.
        if (btn_s) begin
          state_n = HELD;
        end else if (cnt == CNT_LAST) begin
          state_n = IDLE;
        end else begin
          cnt_n = cnt + 1'b1;
        end
      end
      default: state_n = IDLE;
    endcase
    level_n = (state_n == HELD) || (state_n == RELEASE_WAIT);
  end

endmodule

// File: tb/tb_button_debounce_pulse.sv
// tb/tb_button_debounce_pulse.sv - directed vector bench for button_debounce_pulse
module tb_button_debounce_pulse;

  logic clk = 1'b0;
  logic reset;
  logic btn_in;
  logic pulse, level;
  logic pulse_r, level_r;
  logic [3:0] count4;

  int n_cmp = 0;
  int n_bad = 0;

  typedef struct {
    logic btn;
    logic rst;
    logic exp_pulse;
    logic exp_level;
  } vec_t;

  vec_t vecs[$];

  always #5 clk = ~clk;

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (0),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4)
  ) dut (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .pulse  (pulse),
    .level  (level)
  );

  button_debounce_pulse #(
    .DEBOUNCE_CYCLES (4),
    .REPEAT_EN       (1),
    .REPEAT_DELAY    (8),
    .REPEAT_PERIOD   (4)
  ) dut_rep (
    .clk    (clk),
    .reset  (reset),
    .btn_in (btn_in),
    .pulse  (pulse_r),
    .level  (level_r)
  );

  // Downstream 4-bit counter fed directly by the strobe.
  always @(posedge clk) begin
    if (reset) count4 <= 4'd0;
    else if (pulse) count4 <= count4 + 4'd1;
  end

  task automatic step(input logic b, input logic r);
    btn_in = b;
    reset  = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int idx, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s[%0d]: got %0d expected %0d", name, idx, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic b, input logic r, input logic p, input logic l);
    vec_t v;
    v.btn = b;
    v.rst = r;
    v.exp_pulse = p;
    v.exp_level = l;
    return v;
  endfunction

  task automatic press_release();
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0);
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);
  endtask

  initial begin
    // Clean press 12 cycles, release 10 cycles.
    for (int i = 1; i <= 22; i++)
      vecs.push_back(mk(i <= 12, 1'b0, i == 7, (i >= 7) && (i <= 18)));
    // Bounce: high 2, low 1, high 2, low 1, high 10.
    for (int i = 1; i <= 16; i++)
      vecs.push_back(mk(!((i == 3) || (i == 6)), 1'b0, i == 13, i >= 13));
    // Two-cycle release glitch while held.
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(i > 2, 1'b0, 1'b0, 1'b1));
    // Final release back to idle.
    for (int i = 1; i <= 8; i++)
      vecs.push_back(mk(1'b0, 1'b0, 1'b0, i <= 6));

    btn_in = 1'b0;
    reset  = 1'b1;
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    check("reset_pulse", 0, pulse, 0);
    check("reset_level", 0, level, 0);
    check("reset_pulse_rep", 0, pulse_r, 0);
    check("reset_level_rep", 0, level_r, 0);

    foreach (vecs[i]) begin
      step(vecs[i].btn, vecs[i].rst);
      check("vec_pulse", i, pulse, vecs[i].exp_pulse);
      check("vec_level", i, level, vecs[i].exp_level);
    end

    // Auto-repeat while held for 30 cycles.
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    for (int i = 1; i <= 30; i++) begin
      step(1'b1, 1'b0);
      check("rep_pulse", i, pulse_r,
            (i == 7) || (i == 15) || (i == 19) || (i == 23) || (i == 27));
      check("norep_pulse", i, pulse, i == 7);
    end
    for (int i = 1; i <= 10; i++) begin
      step(1'b0, 1'b0);
      check("norep_release_pulse", i, pulse, 0);
    end
    check("rep_release_level", 0, level_r, 0);
    check("norep_release_level", 0, level, 0);

    // Reset in the middle of PRESS_WAIT with the button still high.
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0);
    for (int i = 1; i <= 2; i++) begin
      step(1'b1, 1'b1);
      check("midreset_pulse", i, pulse, 0);
      check("midreset_level", i, level, 0);
    end
    for (int i = 1; i <= 12; i++) begin
      step(1'b1, 1'b0);
      check("postreset_pulse", i, pulse, i == 7);
      check("postreset_level", i, level, i >= 7);
    end
    for (int i = 0; i < 8; i++) step(1'b0, 1'b0);

    // Strobe drives the 4-bit counter directly.
    step(1'b0, 1'b1);
    check("count_reset", 0, count4, 0);
    for (int p = 0; p < 5; p++) press_release();
    check("count_5", 5, count4, 5);
    for (int p = 5; p < 16; p++) press_release();
    check("count_wrap", 16, count4, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
